frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter N_SPRITES, default 4: sprites updated and plotted per frame, legal range 1..16.
REQ-002 Parameter FRAME_TICKS, default 833333: frame period in clk cycles, giving 60 Hz at 50 MHz; minimum 2.
REQ-003 Derived widths: SW = max(1, clog2(N_SPRITES)); TW = clog2(FRAME_TICKS).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 enable  in  1  run control; when low, no new frame starts.
REQ-007 plot_done  in  1  plotter acknowledge; sampled only in PLOT.
REQ-008 pos_en  out  1  one-cycle position-update strobe for the sprite on sprite_sel.
REQ-009 plot_en  out  1  plot request; held high until acknowledged.
REQ-010 sprite_sel  out  SW  index of the sprite being processed.
REQ-011 frame_tick  out  1  one-cycle pulse at each frame-timer wrap.
REQ-012 busy  out  1  high in every state except WAIT.
REQ-013 overrun  out  1  sticky flag: a frame tick arrived while busy.

Function
REQ-014 Frame timer: TW-bit counter.
- Increments each cycle while enable=1.
- At FRAME_TICKS-1: wraps to 0 and asserts frame_tick for that cycle.
- While enable=0: held at 0.
REQ-015 States: WAIT, UPDATE, PLOT, plus ERASE when ERASE_EN is defined (REQ-027); encoding is free.
REQ-016 WAIT: all strobes low, sprite_sel=0; on frame_tick=1, next state is ERASE when configured, else UPDATE.
REQ-017 UPDATE: pos_en=1 for exactly one cycle, then unconditionally PLOT.
REQ-018 PLOT: plot_en=1 every cycle until plot_done=1 is sampled; plot_en drops in the cycle after acknowledge.
- Minimum PLOT dwell is one cycle; plot_done already high on PLOT entry is accepted in that first cycle.
REQ-019 On acknowledge:
- sprite_sel = N_SPRITES-1: return to WAIT, sprite_sel returns to 0.
- Otherwise: sprite_sel increments by 1, then ERASE/UPDATE.
REQ-020 sprite_sel changes only on the acknowledge edge or reset; it never exceeds N_SPRITES-1.
REQ-021 plot_done outside PLOT: ignored, no state effect.
REQ-022 frame_tick while busy=1: overrun set to 1, tick dropped, current frame continues; overrun stays set until reset.
REQ-023 frame_tick and the final acknowledge in the same cycle: overrun set, FSM goes to WAIT, tick not re-used.
REQ-024 enable falling mid-frame: current frame completes normally; FSM then remains in WAIT.
REQ-025 Outputs are decoded from registered state only; no combinational path from plot_done to any output.

Reset
REQ-026 While reset=1:
- State WAIT; timer 0; sprite_sel 0.
- pos_en, plot_en, frame_tick, busy, overrun all 0 (plus erase_en when configured).
- Applies from any state, including mid-PLOT with plot_en high.

Configuration
REQ-027 Macro FRAME_SEQUENCER_ERASE_EN enables the erase-before-plot feature.
REQ-028 When FRAME_SEQUENCER_ERASE_EN is defined:
- Adds ports erase_en (out 1) and erase_done (in 1).
- ERASE state precedes every UPDATE.
- In ERASE, erase_en is held high until erase_done=1 is sampled, then the FSM goes to UPDATE.
- Handshake rules are those of REQ-018/REQ-021 applied to erase_en/erase_done.
REQ-029 When FRAME_SEQUENCER_ERASE_EN is undefined: no ERASE state, no erase ports; behaviour as REQ-016/REQ-019.

Verification (N_SPRITES=3, FRAME_TICKS=8 unless stated)
REQ-030 Basic frame (enable=1, plot_done tied 1):
- Tick at cycle 7 after reset release.
- pos_en pulses with sprite_sel=0, 1, 2.
- Each pos_en is followed by one plot_en cycle.
- busy back to 0 by cycle 14; overrun=0.
REQ-031 Plot stall: plot_done held 0 for 4 PLOT cycles on sprite 1 -> plot_en high 5 cycles, sprite_sel stays 1, then advances to 2.
REQ-032 Overrun: plot_done held 0 for 10 cycles -> overrun=1 at the second tick; frame completes; next frame starts on the third tick.
REQ-033 Reset mid-PLOT: reset asserted with plot_en=1 -> outputs go 0 without waiting for a clock edge; after release the timer restarts from 0.
REQ-034 N_SPRITES=1: sprite_sel is constantly 0; each tick gives one pos_en, then plot_en, then WAIT.
REQ-035 ERASE_EN defined: per sprite, order erase_en...erase_done -> pos_en -> plot_en...plot_done; erase_done pulsed outside ERASE is ignored.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer: frame timer plus a per-sprite update/plot sequencer.
// At each frame tick it walks sprites 0..N_SPRITES-1. For each sprite it
// strobes pos_en for one cycle, then holds plot_en until plot_done.
// Optional feature macro: FRAME_SEQUENCER_ERASE_EN. It adds an
// erase_en/erase_done handshake (ERASE state) ahead of every UPDATE.
// All outputs are decoded from registered state. plot_done and erase_done
// reach only next-state logic, never an output.
module frame_sequencer #(
  parameter int N_SPRITES   = 4,
  parameter int FRAME_TICKS = 833333,
  localparam int SW = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
  localparam int TW = $clog2(FRAME_TICKS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          plot_done,
`ifdef FRAME_SEQUENCER_ERASE_EN
  input  logic          erase_done,
  output logic          erase_en,
`endif
  output logic          pos_en,
  output logic          plot_en,
  output logic [SW-1:0] sprite_sel,
  output logic          frame_tick,
  output logic          busy,
  output logic          overrun
);

  localparam logic [TW-1:0] TIMER_MAX   = TW'(FRAME_TICKS - 1);
  localparam logic [SW-1:0] LAST_SPRITE = SW'(N_SPRITES - 1);

`ifdef FRAME_SEQUENCER_ERASE_EN
  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_UPDATE = 2'd1,
    S_PLOT   = 2'd2,
    S_ERASE  = 2'd3
  } state_t;
  // Every sprite starts with an erase pass when the feature is built in
  localparam state_t SPRITE_START = S_ERASE;
`else
  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_UPDATE = 2'd1,
    S_PLOT   = 2'd2
  } state_t;
  localparam state_t SPRITE_START = S_UPDATE;
`endif

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_timer;
  logic [SW-1:0]   r_sel;
  logic            r_overrun;
  logic            w_tick;
  logic            w_plot_ack;
  logic            w_last_sprite;

  // The wrap cycle of the frame timer is the frame tick. It is only seen
  // while enabled, so a disabled sequencer never starts a new frame.
  assign w_tick        = enable && (r_timer == TIMER_MAX);
  assign w_plot_ack    = (r_state == S_PLOT) && plot_done;
  assign w_last_sprite = (r_sel == LAST_SPRITE);

  // Frame timer: free-runs while enabled, wraps at FRAME_TICKS-1, parks at 0 when disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (!enable) begin
      r_timer <= '0;
    end else if (r_timer == TIMER_MAX) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. Ticks are only honoured in WAIT. A tick that lands
  // mid-frame, including on the final acknowledge, is dropped here.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT: begin
        if (w_tick) begin
          w_next = SPRITE_START;
        end
      end
`ifdef FRAME_SEQUENCER_ERASE_EN
      S_ERASE: begin
        if (erase_done) begin
          w_next = S_UPDATE;
        end
      end
`endif
      S_UPDATE: begin
        w_next = S_PLOT;
      end
      S_PLOT: begin
        if (plot_done) begin
          w_next = w_last_sprite ? S_WAIT : SPRITE_START;
        end
      end
      default: begin
        w_next = S_WAIT;
      end
    endcase
  end

  // Sprite index moves only on a plot acknowledge. It wraps to 0 after the last sprite.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel <= '0;
    end else if (w_plot_ack) begin
      r_sel <= w_last_sprite ? '0 : (r_sel + SW'(1));
    end
  end

  // Sticky overrun: a frame tick seen while a frame is still in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_tick && (r_state != S_WAIT)) begin
      r_overrun <= 1'b1;
    end
  end

  // Output decode from the registered state only
  always_comb begin
    pos_en  = (r_state == S_UPDATE);
    plot_en = (r_state == S_PLOT);
    busy    = (r_state != S_WAIT);
`ifdef FRAME_SEQUENCER_ERASE_EN
    erase_en = (r_state == S_ERASE);
`endif
  end

  assign sprite_sel = r_sel;
  assign frame_tick = w_tick;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: self-checking bench for frame_sequencer.
// Two instances share the stimulus: N_SPRITES=3 and N_SPRITES=1, both
// with FRAME_TICKS=8. A sprite-walk reference model predicts every cycle.
module tb_frame_sequencer;

  localparam int FT = 8;
  localparam int NA = 3;
  localparam int NB = 1;
  localparam int PH_ERASE  = 0;
  localparam int PH_UPDATE = 1;
  localparam int PH_PLOT   = 2;
`ifdef FRAME_SEQUENCER_ERASE_EN
  localparam int FIRST_PH = PH_ERASE;
`else
  localparam int FIRST_PH = PH_UPDATE;
`endif

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic plotDone;
  logic eraseDone;

  logic       posEnA, plotEnA, tickA, busyA, ovrA, eraseEnA;
  logic [1:0] selA;
  logic       posEnB, plotEnB, tickB, busyB, ovrB, eraseEnB;
  logic [0:0] selB;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per instance, frame in progress, current sprite, and
  // which step of that sprite's work is pending
  int mTimer[2];
  bit mActive[2];
  int mPhase[2];
  int mSprite[2];
  bit mOvr[2];
  int mN[2] = '{NA, NB};

  bit countOn = 1'b0;
  int plotSel1Cnt = 0;

  always #5 clk = ~clk;

  frame_sequencer #(.N_SPRITES(NA), .FRAME_TICKS(FT)) dutA (
    .clk(clk), .reset(reset), .enable(enable), .plot_done(plotDone),
`ifdef FRAME_SEQUENCER_ERASE_EN
    .erase_done(eraseDone), .erase_en(eraseEnA),
`endif
    .pos_en(posEnA), .plot_en(plotEnA), .sprite_sel(selA),
    .frame_tick(tickA), .busy(busyA), .overrun(ovrA)
  );

  frame_sequencer #(.N_SPRITES(NB), .FRAME_TICKS(FT)) dutB (
    .clk(clk), .reset(reset), .enable(enable), .plot_done(plotDone),
`ifdef FRAME_SEQUENCER_ERASE_EN
    .erase_done(eraseDone), .erase_en(eraseEnB),
`endif
    .pos_en(posEnB), .plot_en(plotEnB), .sprite_sel(selB),
    .frame_tick(tickB), .busy(busyB), .overrun(ovrB)
  );

`ifndef FRAME_SEQUENCER_ERASE_EN
  assign eraseEnA = 1'b0;
  assign eraseEnB = 1'b0;
`endif

  // Counts plot_en cycles spent on sprite 1 during the stall sequence
  always @(negedge clk) begin
    if (countOn && plotEnA && (selA == 2'd1)) plotSel1Cnt++;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Output packing: {busy, pos_en, plot_en, frame_tick, overrun, erase_en, sel[3:0]}
  function automatic logic [9:0] packA();
    return {busyA, posEnA, plotEnA, tickA, ovrA, eraseEnA, 2'b00, selA};
  endfunction

  function automatic logic [9:0] packB();
    return {busyB, posEnB, plotEnB, tickB, ovrB, eraseEnB, 3'b000, selB};
  endfunction

  function automatic logic [9:0] expOut(int k, logic en);
    logic b, p, pl, t, er;
    b  = mActive[k];
    p  = mActive[k] && (mPhase[k] == PH_UPDATE);
    pl = mActive[k] && (mPhase[k] == PH_PLOT);
    er = mActive[k] && (mPhase[k] == PH_ERASE);
    t  = en && (mTimer[k] == FT - 1);
    return {b, p, pl, t, mOvr[k], er, 4'(mSprite[k])};
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mTimer[k] = 0; mActive[k] = 1'b0; mPhase[k] = PH_UPDATE;
      mSprite[k] = 0; mOvr[k] = 1'b0;
    end
  endtask

  task automatic modelStep(input logic en, input logic pd, input logic ed);
    bit tick;
    for (int k = 0; k < 2; k++) begin
      tick = en && (mTimer[k] == FT - 1);
      if (mActive[k]) begin
        if (tick) mOvr[k] = 1'b1;
        if (mPhase[k] == PH_ERASE) begin
          if (ed) mPhase[k] = PH_UPDATE;
        end else if (mPhase[k] == PH_UPDATE) begin
          mPhase[k] = PH_PLOT;
        end else if (pd) begin
          if (mSprite[k] == mN[k] - 1) begin
            mActive[k] = 1'b0;
            mSprite[k] = 0;
          end else begin
            mSprite[k] = mSprite[k] + 1;
            mPhase[k]  = FIRST_PH;
          end
        end
      end else if (tick) begin
        mActive[k] = 1'b1;
        mPhase[k]  = FIRST_PH;
      end
      mTimer[k] = !en ? 0 : ((mTimer[k] == FT - 1) ? 0 : mTimer[k] + 1);
    end
  endtask

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    compareVal({name, "/A"}, 32'(packA()), 32'(expOut(0, enable)));
    compareVal({name, "/B"}, 32'(packB()), 32'(expOut(1, enable)));
  endtask

  task automatic applyStimulus(input logic en, input logic pd, input logic ed);
    enable    = en;
    plotDone  = pd;
    eraseDone = ed;
  endtask

  // One full cycle: drive, check mid-cycle, clock, advance the model
  task automatic step(input logic en, input logic pd, input logic ed, input string name);
    applyStimulus(en, pd, ed);
    @(negedge clk);
    checkOutput(name);
    @(posedge clk);
    modelStep(en, pd, ed);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic       pd;
    logic       busy;
    logic       pos;
    logic       plot;
    logic       tick;
    logic       ovr;
    logic [1:0] sel;
  } vec_t;

  vec_t tbl[15];

  initial begin
    bit seenActive;
    bit stallNow;
    int stallCnt;
    int tickCnt;
    logic pd;

    // Basic frame with plot_done tied high, cycles counted from reset release
    for (int i = 0; i < 15; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[7].tick  = 1'b1;
    tbl[8].busy  = 1'b1; tbl[8].pos   = 1'b1; tbl[8].sel  = 2'd0;
    tbl[9].busy  = 1'b1; tbl[9].plot  = 1'b1; tbl[9].sel  = 2'd0;
    tbl[10].busy = 1'b1; tbl[10].pos  = 1'b1; tbl[10].sel = 2'd1;
    tbl[11].busy = 1'b1; tbl[11].plot = 1'b1; tbl[11].sel = 2'd1;
    tbl[12].busy = 1'b1; tbl[12].pos  = 1'b1; tbl[12].sel = 2'd2;
    tbl[13].busy = 1'b1; tbl[13].plot = 1'b1; tbl[13].sel = 2'd2;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].en, tbl[i].pd, 1'b1);
      @(negedge clk);
`ifndef FRAME_SEQUENCER_ERASE_EN
      compareVal($sformatf("basic[%0d]", i),
                 32'({busyA, posEnA, plotEnA, tickA, ovrA, selA}),
                 32'({tbl[i].busy, tbl[i].pos, tbl[i].plot, tbl[i].tick, tbl[i].ovr, tbl[i].sel}));
`endif
      checkOutput("basic-model");
      @(posedge clk);
      modelStep(tbl[i].en, tbl[i].pd, 1'b1);
      #1;
    end

    // Plot stall on sprite 1; enable drops once the frame starts, so the frame finishes without overrun
    $display("[TB] plot stall sequence");
    seenActive = 1'b0;
    stallCnt = 0;
    plotSel1Cnt = 0;
    countOn = 1'b1;
    for (int c = 0; c < 40; c++) begin
      stallNow = mActive[0] && (mPhase[0] == PH_PLOT) && (mSprite[0] == 1) && (stallCnt < 4);
      if (stallNow) stallCnt++;
      step(seenActive ? 1'b0 : 1'b1, !stallNow, 1'b1, "stall");
      if (mActive[0]) seenActive = 1'b1;
      else if (seenActive) break;
    end
    countOn = 1'b0;
    compareVal("stall plot_en cycles on sprite1", 32'(plotSel1Cnt), 32'd5);
    compareVal("stall overrun", 32'(ovrA), 32'd0);

    // Overrun: first plot held off for 10 cycles so the second tick lands mid-frame
    $display("[TB] overrun sequence");
    stallCnt = 0;
    tickCnt = 0;
    for (int c = 0; c < 40; c++) begin
      stallNow = mActive[0] && (mPhase[0] == PH_PLOT) && (stallCnt < 10);
      if (stallNow) stallCnt++;
      if (mTimer[0] == FT - 1) tickCnt++;
      step(1'b1, !stallNow, 1'b1, "overrun");
      if (tickCnt == 2 && mTimer[0] == 0) compareVal("overrun at second tick", 32'(ovrA), 32'd1);
    end
    compareVal("overrun sticky", 32'(ovrA), 32'd1);

    // Asynchronous reset while plot_en is high
    $display("[TB] reset mid-plot sequence");
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b0, 1'b1, "pre-reset");
      if (mActive[0] && (mPhase[0] == PH_PLOT)) break;
    end
    #2;
    compareVal("plot_en before reset", 32'(plotEnA), 32'd1);
    reset = 1'b1;
    #1;
    compareVal("async reset A", 32'(packA()), 32'd0);
    compareVal("async reset B", 32'(packB()), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 12; c++) step(1'b1, 1'b1, 1'b1, "post-reset");

    // Randomized traffic, including acknowledges outside their handshake state
    $display("[TB] random sequence");
    for (int c = 0; c < 500; c++) begin
      pd = ($urandom_range(0, 2) == 0);
      step($urandom_range(0, 19) != 0, pd, 1'($urandom_range(0, 1)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
